// File: rtl/gic_pkg.sv
// gic_pkg: shared ID width, per-CPU delivery states and ID reset constant for the GIC CPU router.
package gic_pkg;
    localparam int IRQ_ID_W = 11;
    localparam logic [IRQ_ID_W-1:0] ID_RST = '0;
    typedef enum logic [1:0] {IDLE, SIGNAL, ACTIVE, EOI} cpu_state_e;
endpackage

// File: rtl/gic_rr_arbiter.sv
// gic_rr_arbiter: round-robin one-hot grant starting at rr_ptr, pointer moves past each grant.
module gic_rr_arbiter #(
    parameter int N = 8,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);
    logic [PW-1:0] ptr_q, ptr_d;
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++)
            if (!gnt_vld_o && req_i[(int'(ptr_q) + k) % N]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = PW'((int'(ptr_q) + k) % N);
            end
        gnt_o = gnt_vld_o ? N'(1) << gnt_idx_o : '0;
        ptr_d = !gnt_vld_o ? ptr_q : gnt_idx_o == PW'(N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
endmodule

// File: rtl/gic_cpu_router.sv
// gic_cpu_router: per-CPU pending slot, IRQ/ack/EOI tracking and round-robin EOI return.
// Define GIC_ROUTER_ACK_TIMEOUT_EN to add per-CPU ack-timeout counters driving err_timeout.
module gic_cpu_router
    import gic_pkg::*;
#(
    parameter int NUM_CPUS    = 8,
    parameter int ID_WIDTH    = IRQ_ID_W,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_valid,
    output logic                         spi_ready,
    input  logic [ID_WIDTH-1:0]          spi_id,
    input  logic [NUM_CPUS-1:0]          spi_target,
    output logic [NUM_CPUS-1:0]          cpu_irq,
    output logic [NUM_CPUS*ID_WIDTH-1:0] cpu_irq_id,
    input  logic [NUM_CPUS-1:0]          cpu_ack,
    input  logic [NUM_CPUS-1:0]          cpu_eoi,
    output logic                         eoi_valid,
    output logic [ID_WIDTH-1:0]          eoi_id,
    output logic                         err_proto,
    output logic                         err_timeout
);
    localparam int PW = NUM_CPUS > 1 ? $clog2(NUM_CPUS) : 1;
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be positive");
    end
    cpu_state_e state_q [NUM_CPUS], state_d [NUM_CPUS];
    logic [ID_WIDTH-1:0] slot_id_q [NUM_CPUS], slot_id_d [NUM_CPUS];
    logic [ID_WIDTH-1:0] active_id_q [NUM_CPUS], active_id_d [NUM_CPUS];
    logic [ID_WIDTH-1:0] irq_id_q [NUM_CPUS], irq_id_d [NUM_CPUS];
    logic [NUM_CPUS-1:0] slot_vld_q, slot_vld_d, eoi_req, gnt, ack_err, eoi_err;
    logic [ID_WIDTH-1:0] eoi_id_q, eoi_id_d;
    logic [PW-1:0] gnt_idx;
    logic gnt_vld, xfer, eoi_valid_q, err_proto_q, err_proto_d;
    // Ready looks only at registered slots so a freed slot is refillable one cycle after ack.
    assign spi_ready = ~|(spi_target & slot_vld_q);
    assign xfer = spi_valid & spi_ready;
    assign eoi_valid = eoi_valid_q;
    assign eoi_id = eoi_id_q;
    assign err_proto = err_proto_q;
    always_comb
        for (int i = 0; i < NUM_CPUS; i++) begin
            eoi_req[i] = state_q[i] == EOI;
            cpu_irq[i] = state_q[i] == SIGNAL;
            cpu_irq_id[i*ID_WIDTH +: ID_WIDTH] = irq_id_q[i];
        end
    gic_rr_arbiter #(.N(NUM_CPUS)) u_eoi_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (eoi_req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );
    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            state_d[i] = state_q[i];
            slot_vld_d[i] = slot_vld_q[i];
            slot_id_d[i] = slot_id_q[i];
            active_id_d[i] = active_id_q[i];
            irq_id_d[i] = irq_id_q[i];
            ack_err[i] = cpu_ack[i] && state_q[i] != SIGNAL;
            eoi_err[i] = cpu_eoi[i] && state_q[i] != ACTIVE;
            if (xfer && spi_target[i]) begin
                slot_vld_d[i] = 1'b1;
                slot_id_d[i] = spi_id;
            end
            case (state_q[i])
                IDLE: if (slot_vld_q[i]) begin
                    state_d[i] = SIGNAL;
                    irq_id_d[i] = slot_id_q[i];
                end
                SIGNAL: if (cpu_ack[i]) begin
                    state_d[i] = ACTIVE;
                    active_id_d[i] = slot_id_q[i];
                    slot_vld_d[i] = 1'b0;
                end
                ACTIVE: if (cpu_eoi[i]) state_d[i] = EOI;
                EOI: if (gnt[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
        eoi_id_d = gnt_vld ? active_id_q[gnt_idx] : eoi_id_q;
        err_proto_d = |ack_err || |eoi_err || (xfer && spi_target == '0);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                state_q[i] <= IDLE;
                slot_id_q[i] <= ID_WIDTH'(ID_RST);
                active_id_q[i] <= ID_WIDTH'(ID_RST);
                irq_id_q[i] <= ID_WIDTH'(ID_RST);
            end
            slot_vld_q <= '0;
            eoi_valid_q <= 1'b0;
            eoi_id_q <= ID_WIDTH'(ID_RST);
            err_proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_id_q <= slot_id_d;
            active_id_q <= active_id_d;
            irq_id_q <= irq_id_d;
            slot_vld_q <= slot_vld_d;
            eoi_valid_q <= gnt_vld;
            eoi_id_q <= eoi_id_d;
            err_proto_q <= err_proto_d;
        end
`ifdef GIC_ROUTER_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] cnt_q [NUM_CPUS], cnt_d [NUM_CPUS];
    logic [NUM_CPUS-1:0] to_hit;
    logic err_timeout_q;
    // Counters idle at zero outside SIGNAL and saturate at the limit, so each wait pulses once.
    always_comb
        for (int i = 0; i < NUM_CPUS; i++) begin
            cnt_d[i] = state_q[i] != SIGNAL ? '0 : cnt_q[i] == TW'(ACK_TIMEOUT) ? cnt_q[i] : cnt_q[i] + 1'b1;
            to_hit[i] = state_q[i] == SIGNAL && cnt_q[i] == TW'(ACK_TIMEOUT - 1);
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NUM_CPUS; i++) cnt_q[i] <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_timeout_q <= |to_hit;
        end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_gic_cpu_router.sv
// tb_gic_cpu_router: directed scenarios for delivery, broadcast, pending refill, EOI round-robin, errors and reset.
module tb_gic_cpu_router;
    logic        clk = 1'b0, rst_n = 1'b0, spi_valid = 1'b0, spi_ready;
    logic [10:0] spi_id = '0, eoi_id;
    logic [7:0]  spi_target = '0, cpu_irq, cpu_ack = '0, cpu_eoi = '0;
    logic [87:0] cpu_irq_id;
    logic        eoi_valid, err_proto, err_timeout;
    int checks = 0, errors = 0;

    gic_cpu_router #(.NUM_CPUS(8), .ID_WIDTH(11), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .spi_valid(spi_valid), .spi_ready(spi_ready),
        .spi_id(spi_id), .spi_target(spi_target), .cpu_irq(cpu_irq), .cpu_irq_id(cpu_irq_id),
        .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .eoi_valid(eoi_valid), .eoi_id(eoi_id),
        .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [10:0] id_of(int i);
        return cpu_irq_id[i*11 +: 11];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        spi_valid = 0; spi_target = 0; spi_id = 0; cpu_ack = 0; cpu_eoi = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset;
        do_reset;
        spi_target = 8'hFF; #1;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL reset_irq got %h exp 00", cpu_irq); end
        checks++; if (cpu_irq_id !== 88'h0) begin errors++; $display("FAIL reset_irq_id got %h exp 0", cpu_irq_id); end
        checks++; if (eoi_valid !== 1'b0) begin errors++; $display("FAIL reset_eoi_valid got %b exp 0", eoi_valid); end
        checks++; if (eoi_id !== 11'd0) begin errors++; $display("FAIL reset_eoi_id got %0d exp 0", eoi_id); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL reset_err_proto got %b exp 0", err_proto); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got %b exp 0", err_timeout); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", spi_ready); end
        spi_target = 0;
    endtask

    task automatic test_single;
        do_reset;
        spi_id = 37; spi_target = 8'h01; spi_valid = 1; #1;
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", spi_ready); end
        tick; spi_valid = 0;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL single_irq_early got %h exp 00", cpu_irq); end
        tick;
        checks++; if (cpu_irq !== 8'h01) begin errors++; $display("FAIL single_irq got %h exp 01", cpu_irq); end
        checks++; if (id_of(0) !== 11'd37) begin errors++; $display("FAIL single_irq_id got %0d exp 37", id_of(0)); end
        cpu_ack = 8'h01; tick; cpu_ack = 0;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL single_irq_after_ack got %h exp 00", cpu_irq); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL single_no_proto got %b exp 0", err_proto); end
        cpu_eoi = 8'h01; tick; cpu_eoi = 0;
        checks++; if (eoi_valid !== 1'b0) begin errors++; $display("FAIL single_eoi_early got %b exp 0", eoi_valid); end
        tick;
        checks++; if (eoi_valid !== 1'b1) begin errors++; $display("FAIL single_eoi_valid got %b exp 1", eoi_valid); end
        checks++; if (eoi_id !== 11'd37) begin errors++; $display("FAIL single_eoi_id got %0d exp 37", eoi_id); end
        tick;
        checks++; if (eoi_valid !== 1'b0) begin errors++; $display("FAIL single_eoi_pulse got %b exp 0", eoi_valid); end
        checks++; if (id_of(0) !== 11'd37) begin errors++; $display("FAIL single_id_hold got %0d exp 37", id_of(0)); end
    endtask

    task automatic test_broadcast;
        do_reset;
        spi_id = 12; spi_target = 8'h05; spi_valid = 1;
        tick; spi_valid = 0;
        tick;
        checks++; if (cpu_irq !== 8'h05) begin errors++; $display("FAIL bcast_irq got %h exp 05", cpu_irq); end
        checks++; if (id_of(0) !== 11'd12) begin errors++; $display("FAIL bcast_id0 got %0d exp 12", id_of(0)); end
        checks++; if (id_of(2) !== 11'd12) begin errors++; $display("FAIL bcast_id2 got %0d exp 12", id_of(2)); end
        spi_id = 20; spi_target = 8'h01; spi_valid = 1; #1;
        checks++; if (spi_ready !== 1'b0) begin errors++; $display("FAIL bcast_blocked got %b exp 0", spi_ready); end
        tick;
        checks++; if (spi_ready !== 1'b0) begin errors++; $display("FAIL bcast_still_blocked got %b exp 0", spi_ready); end
        cpu_ack = 8'h01; tick; cpu_ack = 0;
        checks++; if (cpu_irq !== 8'h04) begin errors++; $display("FAIL bcast_irq_after_ack got %h exp 04", cpu_irq); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready_after_ack got %b exp 1", spi_ready); end
        tick; spi_valid = 0;
        checks++; if (spi_ready !== 1'b0) begin errors++; $display("FAIL bcast_refilled got %b exp 0", spi_ready); end
        tick;
        checks++; if (cpu_irq !== 8'h04) begin errors++; $display("FAIL bcast_pending_quiet got %h exp 04", cpu_irq); end
    endtask

    task automatic test_active_pending;
        do_reset;
        spi_id = 3; spi_target = 8'h02; spi_valid = 1;
        tick; spi_valid = 0;
        tick;
        cpu_ack = 8'h02; tick; cpu_ack = 0;
        spi_valid = 1; #1;
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL ap_ready got %b exp 1", spi_ready); end
        tick; spi_valid = 0;
        tick;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL ap_no_signal got %h exp 00", cpu_irq); end
        cpu_eoi = 8'h02; tick; cpu_eoi = 0;
        tick;
        checks++; if (eoi_valid !== 1'b1) begin errors++; $display("FAIL ap_eoi_valid got %b exp 1", eoi_valid); end
        checks++; if (eoi_id !== 11'd3) begin errors++; $display("FAIL ap_eoi_id got %0d exp 3", eoi_id); end
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL ap_irq_at_eoi got %h exp 00", cpu_irq); end
        tick;
        checks++; if (cpu_irq !== 8'h02) begin errors++; $display("FAIL ap_resignal got %h exp 02", cpu_irq); end
        checks++; if (id_of(1) !== 11'd3) begin errors++; $display("FAIL ap_resignal_id got %0d exp 3", id_of(1)); end
    endtask

    task automatic test_back_to_back_eoi;
        logic [10:0] exp_ids [3];
        exp_ids = '{11'd107, 11'd100, 11'd103};
        do_reset;
        spi_id = 50; spi_target = 8'h08; spi_valid = 1;
        tick; spi_valid = 0;
        tick;
        cpu_ack = 8'h08; tick; cpu_ack = 0;
        cpu_eoi = 8'h08; tick; cpu_eoi = 0;
        tick;
        checks++; if (eoi_valid !== 1'b1 || eoi_id !== 11'd50) begin errors++; $display("FAIL rr_prime got %b/%0d exp 1/50", eoi_valid, eoi_id); end
        spi_valid = 1;
        spi_id = 100; spi_target = 8'h01; tick;
        spi_id = 103; spi_target = 8'h08; tick;
        spi_id = 107; spi_target = 8'h80; tick;
        spi_valid = 0;
        tick;
        checks++; if (cpu_irq !== 8'h89) begin errors++; $display("FAIL rr_irq got %h exp 89", cpu_irq); end
        cpu_ack = 8'h89; tick; cpu_ack = 0;
        cpu_eoi = 8'h89; tick; cpu_eoi = 0;
        checks++; if (eoi_valid !== 1'b0) begin errors++; $display("FAIL rr_eoi_early got %b exp 0", eoi_valid); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (eoi_valid !== 1'b1 || eoi_id !== exp_ids[k]) begin errors++; $display("FAIL rr_order_%0d got %b/%0d exp 1/%0d", k, eoi_valid, eoi_id, exp_ids[k]); end
        end
        tick;
        checks++; if (eoi_valid !== 1'b0) begin errors++; $display("FAIL rr_done got %b exp 0", eoi_valid); end
    endtask

    task automatic test_proto;
        do_reset;
        cpu_ack = 8'h01; tick; cpu_ack = 0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL proto_ack got %b exp 1", err_proto); end
        tick;
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL proto_ack_pulse got %b exp 0", err_proto); end
        spi_id = 5; spi_target = 8'h00; spi_valid = 1; #1;
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL proto_t0_ready got %b exp 1", spi_ready); end
        tick; spi_valid = 0; spi_target = 8'hFF;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL proto_t0 got %b exp 1", err_proto); end
        tick;
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL proto_t0_pulse got %b exp 0", err_proto); end
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL proto_no_irq got %h exp 00", cpu_irq); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL proto_slots_empty got %b exp 1", spi_ready); end
        cpu_eoi = 8'h02; tick; cpu_eoi = 0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL proto_eoi got %b exp 1", err_proto); end
        tick;
        checks++; if (eoi_valid !== 1'b0 || cpu_irq !== 8'h00) begin errors++; $display("FAIL proto_no_change got %b/%h exp 0/00", eoi_valid, cpu_irq); end
    endtask

    task automatic test_timeout;
        int n, pulses;
        logic hit;
        do_reset;
        spi_id = 9; spi_target = 8'h01; spi_valid = 1;
        tick; spi_valid = 0;
        tick;
        checks++; if (cpu_irq !== 8'h01) begin errors++; $display("FAIL to_signal got %h exp 01", cpu_irq); end
`ifdef GIC_ROUTER_ACK_TIMEOUT_EN
        n = 0; hit = 0;
        while (!hit && n < 40) begin
            tick; n++;
            if (err_timeout === 1'b1) hit = 1;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL to_delay got %0d exp 16", n); end
        pulses = 0;
        repeat (20) begin tick; if (err_timeout === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL to_once got %0d exp 0", pulses); end
`else
        pulses = 0; hit = 0; n = 0;
        repeat (40) begin tick; if (err_timeout !== 1'b0) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL to_tied got %0d exp 0", pulses); end
`endif
        checks++; if (cpu_irq !== 8'h01) begin errors++; $display("FAIL to_still_signal got %h exp 01", cpu_irq); end
        cpu_ack = 8'h01; tick; cpu_ack = 0;
        checks++; if (cpu_irq !== 8'h00 || err_proto !== 1'b0) begin errors++; $display("FAIL to_late_ack got %h/%b exp 00/0", cpu_irq, err_proto); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        spi_id = 44; spi_target = 8'h03; spi_valid = 1;
        tick; spi_valid = 0;
        tick;
        cpu_ack = 8'h01; tick; cpu_ack = 0;
        spi_id = 45; spi_target = 8'h01; spi_valid = 1;
        tick; spi_valid = 0; spi_target = 8'hFF;
        checks++; if (cpu_irq !== 8'h02) begin errors++; $display("FAIL mid_pre got %h exp 02", cpu_irq); end
        #2 rst_n = 0; #1;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL mid_irq got %h exp 00", cpu_irq); end
        checks++; if (cpu_irq_id !== 88'h0) begin errors++; $display("FAIL mid_irq_id got %h exp 0", cpu_irq_id); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", spi_ready); end
        checks++; if (eoi_valid !== 1'b0 || eoi_id !== 11'd0 || err_proto !== 1'b0) begin errors++; $display("FAIL mid_eoi got %b/%0d/%b exp 0/0/0", eoi_valid, eoi_id, err_proto); end
        @(posedge clk); #1 rst_n = 1;
        tick; tick;
        checks++; if (cpu_irq !== 8'h00) begin errors++; $display("FAIL mid_no_resignal got %h exp 00", cpu_irq); end
        cpu_eoi = 8'h01; tick; cpu_eoi = 0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL mid_cpu0_idle got %b exp 1", err_proto); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_broadcast;
        test_active_pending;
        test_back_to_back_eoi;
        test_proto;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
